// File: rtl/char_pkg.sv
// Shared constants and types for the character RAM arbiter and its clear engine.
package char_pkg;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ROW_LEN = 64;
  localparam int unsigned DEPTH   = 1 << ADDR_W;

  localparam logic [DATA_W-1:0] CLEAR_VAL = 8'h00;

  typedef enum logic [2:0] {
    GNT_NONE,
    GNT_VGA,
    GNT_CLR,
    GNT_KBD,
    GNT_CPU
  } gnt_t;

  typedef enum logic [1:0] {
    CLR_IDLE,
    CLR_CLEAR,
    CLR_DONE
  } clr_state_t;

  // One RAM access as presented on the ram_* port
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_cmd_t;

endpackage

// File: rtl/char_ram_arbiter_if.sv
// Bus bundle between the requesters/BRAM and the character RAM arbiter.
interface char_ram_arbiter_if;
  import char_pkg::*;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_valid;
  logic [DATA_W-1:0] vga_data;

  logic              kbd_req;
  logic              kbd_we;
  logic [ADDR_W-1:0] kbd_addr;
  logic [DATA_W-1:0] kbd_wdata;
  logic              kbd_ack;
  logic [DATA_W-1:0] kbd_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  vga_req, vga_addr,
    output vga_valid, vga_data,
    input  kbd_req, kbd_we, kbd_addr, kbd_wdata,
    output kbd_ack, kbd_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  clr_start,
    output clr_busy, clr_done,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  // Requester / BRAM side
  modport master (
    output vga_req, vga_addr,
    input  vga_valid, vga_data,
    output kbd_req, kbd_we, kbd_addr, kbd_wdata,
    input  kbd_ack, kbd_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output clr_start,
    input  clr_busy, clr_done,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/char_clear_engine.sv
// Walks every RAM address once writing CLEAR_VAL, yielding to VGA via stall.
module char_clear_engine
  import char_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              req_c,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done
);

  clr_state_t state, state_nxt;
  logic       last_c;

  assign last_c = (addr == '1);

  always_ff @(posedge clk) begin
    if (rst) state <= CLR_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CLR_IDLE:  if (start) state_nxt = CLR_CLEAR;
      CLR_CLEAR: if (!stall && last_c) state_nxt = CLR_DONE;
      CLR_DONE:  state_nxt = CLR_IDLE;
      default:   state_nxt = CLR_IDLE;
    endcase
  end

  always_comb begin
    req_c = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state)
      CLR_CLEAR: begin
        req_c = 1'b1;
        busy  = 1'b1;
      end
      CLR_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Counter advances only on cycles the write actually reaches the RAM
  always_ff @(posedge clk) begin
    if (rst || state != CLR_CLEAR) addr <= '0;
    else if (!stall)               addr <= addr + ADDR_W'(1);
  end

endmodule

// File: rtl/char_ram_arbiter.sv
// Single-port character RAM arbiter: VGA > clear engine > round-robin(kbd, cpu).
module char_ram_arbiter
  import char_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  char_ram_arbiter_if.slave bus
);

  gnt_t              gnt_c;
  ram_cmd_t          cmd_c;
  logic              kbd_elig_c;
  logic              cpu_elig_c;
  logic              clr_req_c;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_busy;
  logic              clr_done;
  logic              kbd_ack;
  logic              cpu_ack;
  logic              vga_valid;
  logic              last_cpu;

  char_clear_engine u_clear (
    .clk   (clk),
    .rst   (rst),
    .start (bus.clr_start),
    .stall (bus.vga_req),
    .req_c (clr_req_c),
    .addr  (clr_addr),
    .busy  (clr_busy),
    .done  (clr_done)
  );

  // A requester being acked this cycle sits out, capping it at one access per two cycles
  always_comb begin
    kbd_elig_c = bus.kbd_req & ~kbd_ack & ~clr_busy;
    cpu_elig_c = bus.cpu_req & ~cpu_ack & ~clr_busy;
    gnt_c      = GNT_NONE;
    if (rst)                         gnt_c = GNT_NONE;
    else if (bus.vga_req)            gnt_c = GNT_VGA;
    else if (clr_req_c)              gnt_c = GNT_CLR;
    else if (kbd_elig_c && cpu_elig_c) gnt_c = last_cpu ? GNT_KBD : GNT_CPU;
    else if (kbd_elig_c)             gnt_c = GNT_KBD;
    else if (cpu_elig_c)             gnt_c = GNT_CPU;
  end

  always_comb begin
    cmd_c = '0;
    unique case (gnt_c)
      GNT_VGA: cmd_c = '{we: 1'b0, addr: bus.vga_addr, wdata: '0};
      GNT_CLR: cmd_c = '{we: 1'b1, addr: clr_addr, wdata: CLEAR_VAL};
      GNT_KBD: cmd_c = '{we: bus.kbd_we, addr: bus.kbd_addr, wdata: bus.kbd_wdata};
      GNT_CPU: cmd_c = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
      default: cmd_c = '0;
    endcase
  end

  assign bus.ram_en    = (gnt_c != GNT_NONE);
  assign bus.ram_we    = cmd_c.we;
  assign bus.ram_addr  = cmd_c.addr;
  assign bus.ram_wdata = cmd_c.wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      kbd_ack   <= 1'b0;
      cpu_ack   <= 1'b0;
      vga_valid <= 1'b0;
      last_cpu  <= 1'b1;
    end else begin
      kbd_ack   <= (gnt_c == GNT_KBD);
      cpu_ack   <= (gnt_c == GNT_CPU);
      vga_valid <= bus.vga_req;
      if (gnt_c == GNT_KBD)      last_cpu <= 1'b0;
      else if (gnt_c == GNT_CPU) last_cpu <= 1'b1;
    end
  end

  // Read data is the BRAM output passed straight through in the ack/valid cycle
  assign bus.kbd_ack   = kbd_ack;
  assign bus.kbd_rdata = bus.ram_rdata;
  assign bus.cpu_ack   = cpu_ack;
  assign bus.cpu_rdata = bus.ram_rdata;
  assign bus.vga_valid = vga_valid;
  assign bus.vga_data  = bus.ram_rdata;
  assign bus.clr_busy  = clr_busy;
  assign bus.clr_done  = clr_done;

endmodule

// File: tb/tb_char_ram_arbiter.sv
// Directed bench for char_ram_arbiter with a behavioural single-port BRAM.
module tb_char_ram_arbiter;
  import char_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  logic [7:0] mem [DEPTH];
  logic       fill_en = 1'b0;
  logic [7:0] fill_val = 8'h00;

  char_ram_arbiter_if bus ();

  char_ram_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // BRAM model: registered read, write-only on write cycles; fill_en preloads every cell
  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= fill_val;
    end else if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input logic [7:0] val);
    fill_val = val;
    fill_en  = 1'b1;
    tick();
    fill_en  = 1'b0;
  endtask

  // Presents one request and waits for its ack; lat = cycles to ack, -1 on timeout
  task automatic do_access(input logic is_cpu, input logic we, input logic [9:0] addr,
                           input logic [7:0] wdata, output logic [7:0] rdata, output int lat);
    lat   = -1;
    rdata = 8'h00;
    if (is_cpu) begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end else begin
      bus.kbd_req = 1'b1; bus.kbd_we = we; bus.kbd_addr = addr; bus.kbd_wdata = wdata;
    end
    for (int c = 1; c <= 64; c++) begin
      tick();
      if ((is_cpu ? bus.cpu_ack : bus.kbd_ack) === 1'b1) begin
        lat   = c;
        rdata = is_cpu ? bus.cpu_rdata : bus.kbd_rdata;
        break;
      end
    end
    if (is_cpu) bus.cpu_req = 1'b0;
    else        bus.kbd_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.kbd_req = 1'b1; bus.kbd_we = 1'b1; bus.kbd_addr = 10'h001; bus.kbd_wdata = 8'h55;
    bus.vga_req = 1'b1; bus.clr_start = 1'b1;
    #1;
    vectors++;
    if (bus.ram_en !== 1'b0 || bus.ram_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ram_idle: ram_en=%b ram_we=%b want 0 0", bus.ram_en, bus.ram_we);
    end
    tick();
    vectors++;
    if (bus.kbd_ack !== 1'b0 || bus.cpu_ack !== 1'b0 || bus.vga_valid !== 1'b0 ||
        bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: kbd_ack=%b cpu_ack=%b vga_valid=%b busy=%b done=%b want all 0",
               bus.kbd_ack, bus.cpu_ack, bus.vga_valid, bus.clr_busy, bus.clr_done);
    end
    bus.kbd_req = 1'b0; bus.vga_req = 1'b0; bus.clr_start = 1'b0;
    rst = 1'b0;
    tick();
    vectors++;
    if (bus.clr_busy !== 1'b0 || bus.kbd_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: busy=%b kbd_ack=%b want 0 0", bus.clr_busy, bus.kbd_ack);
    end
  endtask

  task automatic test_rr_reset();
    bus.kbd_req = 1'b1; bus.kbd_we = 1'b0; bus.kbd_addr = 10'h005;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'h006;
    #1;
    vectors++;
    if (bus.ram_en !== 1'b1 || bus.ram_addr !== 10'h005) begin
      miscompares++;
      $display("FAIL rr_first_tie: ram_en=%b ram_addr=%h want 1 005", bus.ram_en, bus.ram_addr);
    end
    tick();
    bus.kbd_req = 1'b0; bus.cpu_req = 1'b0;
    vectors++;
    if (bus.kbd_ack !== 1'b1 || bus.cpu_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_first_ack: kbd_ack=%b cpu_ack=%b want 1 0", bus.kbd_ack, bus.cpu_ack);
    end
    tick();
  endtask

  task automatic test_kbd_cpu();
    logic [7:0] rd;
    int         lat;
    do_access(1'b0, 1'b1, 10'h040, 8'h1C, rd, lat);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL kbd_write_lat: got %0d want 1", lat);
    end
    do_access(1'b1, 1'b0, 10'h040, 8'h00, rd, lat);
    vectors++;
    if (lat !== 1 || rd !== 8'h1C) begin
      miscompares++;
      $display("FAIL cpu_read_back: lat=%0d rdata=%h want 1 1c", lat, rd);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [9:0] exp_addr;
    bus.kbd_req = 1'b1; bus.kbd_we = 1'b0; bus.kbd_addr = 10'h100;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'h200;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_addr = i[0] ? 10'h200 : 10'h100;
      vectors++;
      if (bus.ram_en !== 1'b1 || bus.ram_addr !== exp_addr) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: ram_en=%b ram_addr=%h want 1 %h", i, bus.ram_en, bus.ram_addr, exp_addr);
      end
      vectors++;
      if (bus.kbd_ack !== i[0] || bus.cpu_ack !== (i >= 2 && !i[0])) begin
        miscompares++;
        $display("FAIL rr_ack[%0d]: kbd_ack=%b cpu_ack=%b want %b %b", i, bus.kbd_ack, bus.cpu_ack,
                 i[0], (i >= 2 && !i[0]));
      end
      tick();
    end
    bus.kbd_req = 1'b0; bus.cpu_req = 1'b0;
    vectors++;
    if (bus.cpu_ack !== 1'b1 || bus.kbd_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_last_ack: kbd_ack=%b cpu_ack=%b want 0 1", bus.kbd_ack, bus.cpu_ack);
    end
    tick();
  endtask

  task automatic test_vga_priority();
    int starved = 0;
    bus.vga_req = 1'b1; bus.vga_addr = 10'h040;
    bus.kbd_req = 1'b1; bus.kbd_we = 1'b1; bus.kbd_addr = 10'h300; bus.kbd_wdata = 8'h33;
    for (int i = 0; i < 6; i++) begin
      #1;
      vectors++;
      if (bus.ram_addr !== 10'h040 || bus.ram_we !== 1'b0 || bus.kbd_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL vga_wins[%0d]: ram_addr=%h ram_we=%b kbd_ack=%b want 040 0 0",
                 i, bus.ram_addr, bus.ram_we, bus.kbd_ack);
      end
      if (i > 0) begin
        vectors++;
        if (bus.vga_valid !== 1'b1 || bus.vga_data !== 8'h1C) begin
          miscompares++;
          $display("FAIL vga_read[%0d]: valid=%b data=%h want 1 1c", i, bus.vga_valid, bus.vga_data);
        end
      end
      tick();
    end
    bus.vga_req = 1'b0;
    #1;
    vectors++;
    if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 10'h300 || bus.ram_wdata !== 8'h33) begin
      miscompares++;
      $display("FAIL vga_gap_grant: en=%b we=%b addr=%h wdata=%h want 1 1 300 33",
               bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    tick();
    bus.kbd_req = 1'b0;
    vectors++;
    if (bus.kbd_ack !== 1'b1 || bus.vga_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL vga_gap_ack: kbd_ack=%b vga_valid=%b want 1 0", bus.kbd_ack, bus.vga_valid);
    end
    tick();
    vectors++;
    if (mem[10'h300] !== 8'h33) begin
      miscompares++;
      $display("FAIL vga_gap_write: mem[300]=%h want 33", mem[10'h300]);
    end
    if (starved != 0) miscompares++;
  endtask

  task automatic test_clear_idle();
    int busy_cnt = 0;
    int done_at  = -1;
    int bad      = 0;
    fill_mem(8'hFF);
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      if (bus.clr_busy !== 1'b1) break;
      busy_cnt++;
      if (bus.clr_done === 1'b1) done_at = busy_cnt;
      tick();
    end
    vectors++;
    if (busy_cnt !== 1025 || done_at !== 1025) begin
      miscompares++;
      $display("FAIL clear_idle_timing: busy_cycles=%0d done_at=%0d want 1025 1025", busy_cnt, done_at);
    end
    for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== 8'h00) bad++;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL clear_idle_cells: %0d cells not 00 want 0", bad);
    end
  endtask

  task automatic test_clear_vga();
    int         k        = 0;
    int         busy_cnt = 0;
    int         done_at  = -1;
    int         kbd_early = 0;
    logic       prev_rd  = 1'b0;
    logic [7:0] prev_exp = 8'h00;
    fill_mem(8'hA5);
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    bus.kbd_req = 1'b1; bus.kbd_we = 1'b1; bus.kbd_addr = 10'h010; bus.kbd_wdata = 8'h77;
    while (k < 5000) begin
      if (prev_rd) begin
        vectors++;
        if (bus.vga_valid !== 1'b1 || bus.vga_data !== prev_exp) begin
          miscompares++;
          $display("FAIL clear_vga_read[%0d]: valid=%b data=%h want 1 %h", k - 1, bus.vga_valid, bus.vga_data, prev_exp);
        end
      end
      if (bus.clr_busy !== 1'b1) break;
      busy_cnt++;
      if (bus.clr_done === 1'b1) done_at = k;
      if (bus.kbd_ack === 1'b1)  kbd_early++;
      bus.vga_req  = k[0];
      bus.vga_addr = (k < 1024) ? 10'h3FF : 10'h000;
      prev_rd      = k[0];
      prev_exp     = (k < 1024) ? 8'hA5 : 8'h00;
      tick();
      k++;
    end
    bus.vga_req = 1'b0;
    vectors++;
    if (busy_cnt !== 2048 || done_at !== 2047) begin
      miscompares++;
      $display("FAIL clear_vga_timing: busy_cycles=%0d done_at=%0d want 2048 2047", busy_cnt, done_at);
    end
    vectors++;
    if (kbd_early !== 0) begin
      miscompares++;
      $display("FAIL clear_kbd_blocked: %0d acks while busy want 0", kbd_early);
    end
    tick();
    bus.kbd_req = 1'b0;
    vectors++;
    if (bus.kbd_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_kbd_after: kbd_ack=%b want 1", bus.kbd_ack);
    end
    tick();
    vectors++;
    if (mem[10'h010] !== 8'h77 || mem[10'h3FF] !== 8'h00 || mem[10'h011] !== 8'h00) begin
      miscompares++;
      $display("FAIL clear_vga_cells: mem[010]=%h mem[011]=%h mem[3ff]=%h want 77 00 00",
               mem[10'h010], mem[10'h011], mem[10'h3FF]);
    end
  endtask

  task automatic test_reset_mid_clear();
    int   done_seen = 0;
    logic busy_seen = 1'b1;
    fill_mem(8'hEE);
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    repeat (10'h1F0) tick();
    vectors++;
    if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 10'h1F0) begin
      miscompares++;
      $display("FAIL mid_clear_addr: en=%b we=%b addr=%h want 1 1 1f0", bus.ram_en, bus.ram_we, bus.ram_addr);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.ram_en !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_clear_rst_en: ram_en=%b want 0", bus.ram_en);
    end
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_clear_abort: busy=%b done=%b want 0 0", bus.clr_busy, bus.clr_done);
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.clr_done === 1'b1) done_seen++;
      tick();
    end
    vectors++;
    if (done_seen !== 0 || bus.clr_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_clear_no_done: done_pulses=%0d busy=%b want 0 0", done_seen, bus.clr_busy);
    end
    vectors++;
    if (mem[10'h1EF] !== 8'h00 || mem[10'h1F0] !== 8'hEE || mem[10'h3FF] !== 8'hEE) begin
      miscompares++;
      $display("FAIL mid_clear_cells: mem[1ef]=%h mem[1f0]=%h mem[3ff]=%h want 00 ee ee",
               mem[10'h1EF], mem[10'h1F0], mem[10'h3FF]);
    end
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    vectors++;
    if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 10'h000) begin
      miscompares++;
      $display("FAIL restart_addr: en=%b we=%b addr=%h want 1 1 000", bus.ram_en, bus.ram_we, bus.ram_addr);
    end
    done_seen = 0;
    for (int c = 0; c < 1200; c++) begin
      if (bus.clr_done === 1'b1) done_seen++;
      busy_seen = bus.clr_busy;
      if (busy_seen !== 1'b1) break;
      tick();
    end
    vectors++;
    if (done_seen !== 1 || busy_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_finish: done_pulses=%0d busy=%b want 1 0", done_seen, busy_seen);
    end
  endtask

  initial begin
    bus.vga_req = 1'b0; bus.vga_addr = '0;
    bus.kbd_req = 1'b0; bus.kbd_we = 1'b0; bus.kbd_addr = '0; bus.kbd_wdata = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.clr_start = 1'b0;
    repeat (2) tick();
    fill_val = 8'h00;
    fill_en  = 1'b1;
    tick();
    fill_en  = 1'b0;
    test_reset();
    test_rr_reset();
    test_kbd_cpu();
    test_round_robin();
    test_vga_priority();
    test_clear_idle();
    test_clear_vga();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
